// File: rtl/pc_predict.sv
// pc_predict: fetch-stage program counter with a direct-mapped branch target
// buffer and per-entry saturating direction counters.
//
// Ports
//   CLK, RST        clock (rising edge) and asynchronous active-high reset
//   pcen            advance enable; 0 stalls fetch unless a redirect is present
//   psel            predictor enable; 0 forces sequential fetch
//   PCSrc           redirect select: 0 none, 1 braddr, 2 jump, 3 jraddr
//   braddr          branch / mispredict recovery target
//   jaddr, jPC      jump immediate and PC+4 of the jump instruction
//   jraddr          register jump target
//   upd_en          training strobe from execute
//   upd_pc          PC of the resolved branch
//   upd_taken       resolved direction
//   upd_target      resolved taken target
//   imemaddr        registered fetch PC
//   nPC             imemaddr + 4 (wraps modulo 2^32)
//   pred_taken      prediction for imemaddr
//   pred_target     predicted target (entry target on hit, else 0)
module pc_predict #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pcen,
    input  logic        psel,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] braddr,
    input  logic [25:0] jaddr,
    input  logic [31:0] jPC,
    input  logic [31:0] jraddr,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] imemaddr,
    output logic [31:0] nPC,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = 30 - IDXW;

    // Weakly not taken: MSB clear, remaining bits set (0 for a 1-bit counter).
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    // Weakly taken: MSB set, remaining bits clear.
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    // BTB storage; targets are kept as word addresses.
    logic                valid_q [ENTRIES];
    logic [TAGW-1:0]     tag_q   [ENTRIES];
    logic [29:0]         tgt_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

    logic [IDXW-1:0] lidx;
    logic [TAGW-1:0] ltag;
    logic            lhit;

    logic [IDXW-1:0] uidx;
    logic [TAGW-1:0] utag;
    logic            uhit;

    logic [31:0]     pc_next;
    logic            pc_load;

    // Address bits that are architecturally ignored.
    logic unused_bits;
    assign unused_bits = ^{braddr[1:0], jPC[27:0], jraddr[1:0],
                           upd_pc[1:0], upd_target[1:0], imemaddr[1:0]};

    // ---------------- Lookup on the current fetch PC ----------------
    assign lidx = imemaddr[IDXW+1:2];
    assign ltag = imemaddr[31:IDXW+2];
    assign lhit = valid_q[lidx] && (tag_q[lidx] == ltag);

    assign pred_taken  = psel && lhit && ctr_q[lidx][CTR_BITS-1];
    assign pred_target = lhit ? {tgt_q[lidx], 2'b00} : '0;

    assign nPC = imemaddr + 32'd4;

    // ---------------- Next-PC selection ----------------
    always_comb begin
        pc_next = nPC;
        unique case (PCSrc)
            2'd1:    pc_next = {braddr[31:2], 2'b00};
            2'd2:    pc_next = {jPC[31:28], jaddr, 2'b00};
            2'd3:    pc_next = {jraddr[31:2], 2'b00};
            default: pc_next = pred_taken ? pred_target : nPC;
        endcase
    end

    // A redirect is never lost to a stall.
    assign pc_load = (PCSrc != 2'd0) || pcen;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            imemaddr <= {PC_RESET[31:2], 2'b00};
        end else if (pc_load) begin
            imemaddr <= pc_next;
        end
    end

    // ---------------- Training port ----------------
    assign uidx = upd_pc[IDXW+1:2];
    assign utag = upd_pc[31:IDXW+2];
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (upd_en) begin
            if (uhit) begin
                if (upd_taken) begin
                    if (ctr_q[uidx] != '1) begin
                        ctr_q[uidx] <= ctr_q[uidx] + CTR_ONE;
                    end
                    tgt_q[uidx] <= upd_target[31:2];
                end else if (ctr_q[uidx] != '0) begin
                    ctr_q[uidx] <= ctr_q[uidx] - CTR_ONE;
                end
            end else if (upd_taken) begin
                valid_q[uidx] <= 1'b1;
                tag_q[uidx]   <= utag;
                tgt_q[uidx]   <= upd_target[31:2];
                ctr_q[uidx]   <= CTR_WT;
            end
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed self-checking bench for pc_predict
// (ENTRIES = 16, CTR_BITS = 2, PC_RESET = 0x100).
module tb_pc_predict;

    logic        CLK;
    logic        RST;
    logic        pcen;
    logic        psel;
    logic [1:0]  PCSrc;
    logic [31:0] braddr;
    logic [25:0] jaddr;
    logic [31:0] jPC;
    logic [31:0] jraddr;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] imemaddr;
    logic [31:0] nPC;
    logic        pred_taken;
    logic [31:0] pred_target;

    int unsigned vectors;
    int unsigned miscompares;

    pc_predict #(
        .ENTRIES  (16),
        .CTR_BITS (2),
        .PC_RESET (32'h0000_0100)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pcen        (pcen),
        .psel        (psel),
        .PCSrc       (PCSrc),
        .braddr      (braddr),
        .jaddr       (jaddr),
        .jPC         (jPC),
        .jraddr      (jraddr),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .imemaddr    (imemaddr),
        .nPC         (nPC),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        tick();
        upd_en     = 1'b0;
    endtask

    // Redirect to addr through the branch port, then leave the PC parked there.
    task automatic park(input logic [31:0] addr);
        pcen   = 1'b0;
        PCSrc  = 2'd1;
        braddr = addr;
        tick();
        PCSrc  = 2'd0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST = 1'b1; pcen = 1'b0; psel = 1'b0; PCSrc = 2'd0;
        braddr = '0; jaddr = '0; jPC = '0; jraddr = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

        // Reset
        #1;
        chk("async_reset_pc", imemaddr, 32'h100);
        tick();
        chk("reset_pc", imemaddr, 32'h100);
        chk("reset_npc", nPC, 32'h104);
        chk("reset_pred", {31'd0, pred_taken}, 32'd0);
        chk("reset_ptgt", pred_target, 32'd0);
        RST  = 1'b0;
        pcen = 1'b1;
        tick();
        chk("seq_1", imemaddr, 32'h104);
        tick();
        chk("seq_2", imemaddr, 32'h108);

        // Stall, then redirects override the stall
        pcen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold", imemaddr, 32'h108);
        end
        PCSrc  = 2'd1;
        braddr = 32'h0000_0403;   // low bits must be dropped
        tick();
        chk("branch_redirect", imemaddr, 32'h400);
        PCSrc = 2'd2;
        jPC   = 32'h1000_0008;
        jaddr = 26'h10;
        tick();
        chk("jump_redirect", imemaddr, 32'h1000_0040);
        PCSrc = 2'd0;

        // Allocate and predict
        train(32'h200, 1'b1, 32'h800);
        chk("train_no_fetch", imemaddr, 32'h1000_0040);
        psel = 1'b1;
        park(32'h200);
        chk("alloc_pred", {31'd0, pred_taken}, 32'd1);
        chk("alloc_ptgt", pred_target, 32'h800);
        pcen = 1'b1;
        tick();
        chk("pred_fetch", imemaddr, 32'h800);
        psel = 1'b0;
        park(32'h200);
        chk("psel_off_pred", {31'd0, pred_taken}, 32'd0);
        pcen = 1'b1;
        tick();
        chk("psel_off_fetch", imemaddr, 32'h204);

        // Counter saturation: 10 -> 11 -> 11 -> 11, then 10 (taken), 01 (not taken)
        psel = 1'b1;
        park(32'h200);
        for (int k = 0; k < 3; k++) train(32'h200, 1'b1, 32'h800);
        chk("sat_taken", {31'd0, pred_taken}, 32'd1);
        train(32'h200, 1'b0, 32'h0);
        chk("sat_nt1", {31'd0, pred_taken}, 32'd1);
        train(32'h200, 1'b0, 32'h0);
        chk("sat_nt2", {31'd0, pred_taken}, 32'd0);
        chk("sat_nt2_ptgt", pred_target, 32'h800);
        pcen = 1'b1;
        tick();
        chk("sat_nt2_fetch", imemaddr, 32'h204);

        // Aliasing: 0x240 shares the index of 0x200
        pcen = 1'b0;
        train(32'h200, 1'b1, 32'h800);
        train(32'h240, 1'b1, 32'h900);
        park(32'h200);
        chk("alias_miss_pred", {31'd0, pred_taken}, 32'd0);
        chk("alias_miss_ptgt", pred_target, 32'd0);
        pcen = 1'b1;
        tick();
        chk("alias_miss_fetch", imemaddr, 32'h204);
        park(32'h240);
        chk("alias_hit_ptgt", pred_target, 32'h900);
        pcen = 1'b1;
        tick();
        chk("alias_hit_fetch", imemaddr, 32'h900);

        // Same-cycle update and lookup, redirect wins, then wrap
        pcen = 1'b0;
        train(32'h200, 1'b1, 32'h800);
        park(32'h200);
        chk("pre_same_pred", {31'd0, pred_taken}, 32'd1);
        upd_en = 1'b1; upd_pc = 32'h200; upd_taken = 1'b0; upd_target = '0;
        PCSrc  = 2'd3;
        jraddr = 32'hFFFF_FFFC;
        #1;
        chk("same_old_pred", {31'd0, pred_taken}, 32'd1);
        tick();
        upd_en = 1'b0;
        PCSrc  = 2'd0;
        chk("jr_redirect", imemaddr, 32'hFFFF_FFFC);
        chk("jr_npc_wrap", nPC, 32'h0);
        pcen = 1'b1;
        tick();
        chk("wrap_fetch", imemaddr, 32'h0);
        park(32'h200);
        chk("same_update_landed", {31'd0, pred_taken}, 32'd0);

        // Mid-operation reset with a pending taken update
        train(32'h200, 1'b1, 32'h800);
        chk("pre_reset_pred", {31'd0, pred_taken}, 32'd1);
        upd_en = 1'b1; upd_pc = 32'h280; upd_taken = 1'b1; upd_target = 32'hA00;
        #2;
        RST = 1'b1;
        #1;
        chk("mid_reset_pc", imemaddr, 32'h100);
        chk("mid_reset_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        upd_en = 1'b0;
        RST    = 1'b0;
        #1;
        chk("post_reset_pc", imemaddr, 32'h100);
        park(32'h280);
        chk("aborted_update", {31'd0, pred_taken}, 32'd0);
        park(32'h200);
        chk("btb_cleared", pred_target, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_predict.md
# pc_predict

Parametrised program-counter unit with an integrated branch target buffer (BTB) and per-entry saturating direction counters. It is the successor to the fixed-select PC block. It sits at the head of the fetch stage, drives the instruction memory address, and accepts redirects (branch, jump, jump-register) from later stages. On a BTB hit with a taken counter, it predicts the next fetch address without waiting for resolution. Resolved branches from the execute stage train the BTB through a single update port.

## Interface
Parameters:
- ENTRIES, 16: BTB entries; power of two, at least 2. IDXW = log2(ENTRIES).
- CTR_BITS, 2: width of the saturating counter; at least 1.
- PC_RESET, 32'h0000_0000: PC value on reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous and active-high.
- pcen  in  1  advance enable; 0 = fetch stall.
- psel  in  1  predictor enable; 0 = no prediction, sequential fetch only.
- PCSrc  in  2  redirect select: 0 none, 1 branch (braddr), 2 jump, 3 jump-register (jraddr).
- braddr  in  32  redirect target for branches and mispredict recovery.
- jaddr  in  26  jump immediate.
- jPC  in  32  PC+4 of the jump instruction.
- jraddr  in  32  register jump target.
- upd_en  in  1  training strobe from the execute stage.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved taken target.
- imemaddr  out  32  current fetch PC (registered).
- nPC  out  32  imemaddr + 4.
- pred_taken  out  1  prediction for imemaddr; travels down the pipe with the instruction.
- pred_target  out  32  predicted target; valid when pred_taken = 1.

## Operation
- BTB entry fields: valid, tag = pc[31:IDXW+2], target[31:0], ctr[CTR_BITS-1:0]. Index = pc[IDXW+1:2].
- Lookup is combinational on imemaddr.
  - hit = valid && tag match.
  - pred_taken = psel && hit && ctr MSB.
  - pred_target = the entry's target when hit, otherwise 0.
- Next-PC priority, highest first:
  - PCSrc = 1: braddr.
  - PCSrc = 2: {jPC[31:28], jaddr, 2'b00}.
  - PCSrc = 3: jraddr.
  - pred_taken = 1: pred_target.
  - Otherwise: nPC.
- PC register load rules:
  - PCSrc != 0 loads regardless of pcen, so a redirect overrides a stall.
  - PCSrc = 0 loads only when pcen = 1; with pcen = 0, imemaddr holds.
- Training, when upd_en = 1, at the indexed entry of upd_pc:
  - Hit, taken: ctr increments, saturating at all-ones; target <= upd_target.
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate with valid = 1, new tag, target = upd_target, ctr = weakly taken (MSB = 1, other bits 0). Any existing entry is replaced.
  - Miss, not taken: no change.
- Training is independent of pcen, psel and PCSrc.
- Addresses are word-aligned. Bits [1:0] of every address input are ignored and forced to 0 on imemaddr.
- nPC wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (asynchronous, while RST = 1):
  - imemaddr = PC_RESET; nPC = PC_RESET + 4.
  - All entries: valid = 0; ctr = weakly not taken (MSB = 0, other bits 1; 0 when CTR_BITS = 1).
  - pred_taken = 0; pred_target = 0.
- Reset asserted mid-operation aborts any pending update. The first fetch after release is PC_RESET.
- Lookup-to-fetch latency: 0 cycles. The prediction affects the next imemaddr on the same edge.
- Training latency: 1 cycle. An update written at edge N is visible to lookups from edge N onward.
- Update and lookup hitting the same entry in the same cycle: the lookup uses the pre-update contents. No bypass.
- Redirect latency: 1 edge. imemaddr equals the redirect target in the cycle after PCSrc != 0.
- Redirect and pred_taken in the same cycle: the redirect wins.

## Test plan
- Reset: hold RST high across an edge with PC_RESET = 32'h0000_0100 → imemaddr = 0x100, nPC = 0x104, pred_taken = 0. Release, pcen = 1 → fetch sequence 0x104, 0x108.
- Stall vs redirect: pcen = 0, PCSrc = 0 for 3 cycles → imemaddr held. Then pcen = 0, PCSrc = 1, braddr = 0x400 → next imemaddr = 0x400. Then PCSrc = 2, jPC = 0x1000_0008, jaddr = 26'h10 → 0x1000_0040.
- Allocate and predict: upd_en, upd_pc = 0x200, upd_taken = 1, upd_target = 0x800. Later fetch of 0x200 with psel = 1 → pred_taken = 1, next imemaddr = 0x800. Repeat with psel = 0 → next imemaddr = 0x204.
- Counter saturation (CTR_BITS = 2): after allocation at 2'b10, apply 3 taken updates → 2'b11, still 2'b11. Then 1 not-taken → 2'b10, still predicts taken. Then a 2nd not-taken → 2'b01, pred_taken = 0.
- Aliasing (ENTRIES = 16): train 0x200 taken, then 0x240 (same index, different tag) taken to 0x900 → the 0x200 lookup misses and fetch goes to 0x204; the 0x240 lookup predicts 0x900.
- Simultaneous update and lookup on 0x200, plus PCSrc = 3 with jraddr = 0xFFFF_FFFC: the lookup uses old contents, the redirect wins → imemaddr = 0xFFFF_FFFC, nPC = 0x0000_0000.
